spi_cmd_decoder: RTL and testbench
==================================

// Module: spi_cmd_decoder
// PURPOSE
//  Consumes the byte stream from the SPI slave receiver and interprets it as command frames.
//  - First byte after CS falls is the command.
//  - Following bytes go either to the LED timing config registers or to the frame RAM write port.
//  - Sits between the SPI receiver and the frame RAM / WS2812 waveform generator.
//  - Pulses frame_rdy_out when a data frame completes.
// PARAMETERS
//  ADDR_WIDTH  9     frame RAM byte-address width; depth = 2**ADDR_WIDTH bytes
//  CFG_BYTES   4     number of timing config bytes accepted by CMD_CONF_WR
// PORTS
//  clk_in           in   1           system clock; only clock
//  rst_in           in   1           synchronous, active-high reset
//  spi_cs_n_in      in   1           SPI chip select, asynchronous, active-low
//  byte_rdy_in      in   1           1-cycle strobe, byte_data_in valid (clk_in domain)
//  byte_data_in     in   8           received byte, MSB first already assembled
//  ram_wr_en_out    out  1           frame RAM write strobe, 1 cycle
//  ram_wr_addr_out  out  ADDR_WIDTH  frame RAM byte address
//  ram_wr_data_out  out  8           frame RAM write data
//  cfg_data_out     out  8*CFG_BYTES config regs, byte 0 in [7:0] (T0H,T0L,T1H,T1L)
//  frame_rdy_out    out  1           1-cycle pulse: data frame finished
// BEHAVIOUR
//  Reset (rst_in=1 at clk edge):
//   - state=IDLE, addr counter=0, all outputs 0.
//   - Exception: cfg_data_out = CFG_DEFAULT from package.
//  CS handling:
//   - spi_cs_n_in passes a 2-flop synchronizer plus a rising-edge detect giving cs_end.
//   - cs_end occurs 3 clk after the CS pin rises.
//  Commands (package constants):
//   - CMD_CONF_WR=8'h2A, CMD_DATA_WR=8'h2C.
//   - Any other command value is ignored.
//  FSM states: IDLE, CONF, DATA, DISCARD.
//   - IDLE + byte_rdy:
//     - 8'h2A -> CONF, cfg index=0.
//     - 8'h2C -> DATA, addr=0.
//     - any other value -> DISCARD.
//   - CONF + byte_rdy:
//     - cfg[index] <= byte, index++.
//     - When index reaches CFG_BYTES the FSM goes to DISCARD; extra bytes are ignored.
//     - cfg_data_out updates 1 clk after byte_rdy_in.
//   - DATA + byte_rdy:
//     - ram_wr_en_out=1, addr=counter, data=byte, all registered 1 clk after byte_rdy_in.
//     - Counter then increments.
//     - After writing address 2**ADDR_WIDTH-1 the counter saturates and later bytes are dropped.
//     - No wrap; no write strobe for dropped bytes.
//   - Any state + cs_end -> IDLE.
//     - If leaving DATA with at least 1 byte written, frame_rdy_out=1 for exactly 1 clk on the following cycle.
//     - DATA exited with 0 bytes written: no pulse.
//  Simultaneous byte_rdy_in and cs_end in the same cycle:
//   - The byte is processed first (written or stored).
//   - The FSM then goes to IDLE.
//   - frame_rdy counts that byte.
//  New CS fall with no prior cs_end seen (CS glitch shorter than sync): treated as a continuation; no special action.
//  rst_in mid-frame:
//   - Abort immediately, no frame_rdy pulse.
//   - cfg returns to defaults.
//   - RAM content is untouched.
//  ram_wr_en_out is never high on two consecutive cycles, because byte_rdy_in spacing is at least 8 SCLK.
// STRUCTURE
//  Package led_ctrl_pkg:
//   - CMD_CONF_WR, CMD_DATA_WR.
//   - CFG_DEFAULT.
//   - typedef enum logic [1:0] dec_state_t {IDLE,CONF,DATA,DISCARD}.
//  Sub-module sync_edge_det:
//   - 2-flop synchronizer plus registered rising/falling edge strobes.
//   - Synchronous active-high reset.
//   - Instantiated once on spi_cs_n_in.
//  Rest is one FSM with counters in this module.
// TESTING
//  1 CS low, bytes 2C,11,22,33, CS high:
//    RAM writes (0,11),(1,22),(2,33), each 1 clk after strobe.
//    frame_rdy pulses once, 4 clk after CS rises.
//  2 CS low, 2A,05,0A,0A,05,FF, CS high:
//    cfg_data_out=32'h050A0A05.
//    Byte FF is ignored; no RAM writes; no frame_rdy.
//  3 ADDR_WIDTH=2, 2C then 6 data bytes:
//    Writes at addr 0..3 only; bytes 5,6 produce no strobe.
//    frame_rdy pulses once.
//  4 Command 8'h55 then 3 bytes:
//    No writes, cfg unchanged, no frame_rdy.
//    Next frame 2C,AA writes (0,AA).
//  5 Last data byte strobe coincident with cs_end:
//    Byte written, then IDLE, then frame_rdy.
//    2C with no data then CS high: no frame_rdy.
//  6 rst_in asserted after 2 data bytes:
//    Outputs 0, cfg=CFG_DEFAULT, no frame_rdy.
//    Next frame restarts at addr 0.

Source files
------------

// File: rtl/spi_cmd_decoder_pkg.sv
// Shared command codes, default WS2812 timing and decoder state encoding.
package led_ctrl_pkg;

    localparam logic [7:0]  CMD_CONF_WR = 8'h2A;
    localparam logic [7:0]  CMD_DATA_WR = 8'h2C;

    // T0H, T0L, T1H, T1L in clk_in cycles, byte 0 in the low bits
    localparam logic [31:0] CFG_DEFAULT = 32'h1628_2A14;

    typedef enum logic [1:0] {
        IDLE,
        CONF,
        DATA,
        DISCARD
    } dec_state_t;

    function automatic logic [7:0] cfg_default_byte(input int unsigned idx);
        return CFG_DEFAULT[8*(idx % 4) +: 8];
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Byte stream from the SPI receiver in, frame RAM write port out.
interface spi_cmd_decoder_if #(
    parameter int ADDR_WIDTH = 9
) ();

    logic                  byte_rdy_in;
    logic [7:0]            byte_data_in;
    logic                  ram_wr_en_out;
    logic [ADDR_WIDTH-1:0] ram_wr_addr_out;
    logic [7:0]            ram_wr_data_out;

    modport master (
        output byte_rdy_in,
        output byte_data_in,
        input  ram_wr_en_out,
        input  ram_wr_addr_out,
        input  ram_wr_data_out
    );

    modport slave (
        input  byte_rdy_in,
        input  byte_data_in,
        output ram_wr_en_out,
        output ram_wr_addr_out,
        output ram_wr_data_out
    );

endinterface

// File: rtl/spi_cmd_decoder_sync_edge_det.sv
// Two-flop synchronizer with registered rising/falling edge strobes.
// Latency: strobe is high 3 clk_in edges after the input changes.
// Backpressure: none, strobes are single-cycle and unconditional.
module sync_edge_det #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic async_in,
    output logic rise_out,
    output logic fall_out
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset to the idle level so leaving reset never fakes an edge
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            meta_q   <= RST_VAL;
            sync_q   <= RST_VAL;
            prev_q   <= RST_VAL;
            rise_out <= 1'b0;
            fall_out <= 1'b0;
        end else begin
            meta_q   <= async_in;
            sync_q   <= meta_q;
            prev_q   <= sync_q;
            rise_out <= sync_q & ~prev_q;
            fall_out <= ~sync_q & prev_q;
        end
    end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Decodes SPI command frames into timing config bytes or frame RAM writes.
// Latency: RAM write / cfg update 1 clk after byte_rdy; frame_rdy 4 clk after CS rises.
// Backpressure: none, every byte strobe is consumed or dropped in the cycle it arrives.
module spi_cmd_decoder
    import led_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int CFG_BYTES  = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   spi_cs_n_in,
    spi_cmd_decoder_if.slave       bus,
    output logic [8*CFG_BYTES-1:0] cfg_data_out,
    output logic                   frame_rdy_out
);

    localparam int                    IDX_W     = (CFG_BYTES > 1) ? $clog2(CFG_BYTES) : 1;
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(CFG_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    dec_state_t                 state_q;
    dec_state_t                 state_d;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic                       addr_full_q;
    logic                       wrote_q;
    logic [IDX_W-1:0]           idx_q;
    logic [CFG_BYTES-1:0][7:0]  cfg_q;

    logic cs_end;
    logic cs_fall_unused;
    logic wr_now;
    logic cfg_now;
    logic frame_done;

    sync_edge_det #(
        .RST_VAL (1'b1)
    ) u_cs_sync (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .async_in (spi_cs_n_in),
        .rise_out (cs_end),
        .fall_out (cs_fall_unused)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A byte arriving together with cs_end is still acted on; cs_end only decides the next state
    always_comb begin
        state_d = state_q;
        wr_now  = 1'b0;
        cfg_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.byte_rdy_in) begin
                    if (bus.byte_data_in == CMD_CONF_WR) begin
                        state_d = CONF;
                    end else if (bus.byte_data_in == CMD_DATA_WR) begin
                        state_d = DATA;
                    end else begin
                        state_d = DISCARD;
                    end
                end
            end
            CONF: begin
                if (bus.byte_rdy_in) begin
                    cfg_now = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = DISCARD;
                    end
                end
            end
            DATA: begin
                wr_now = bus.byte_rdy_in & ~addr_full_q;
            end
            DISCARD: begin
                state_d = DISCARD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (cs_end) begin
            state_d = IDLE;
        end
    end

    assign frame_done = cs_end && (state_q == DATA) && (wrote_q || wr_now);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            addr_q              <= '0;
            addr_full_q         <= 1'b0;
            wrote_q             <= 1'b0;
            idx_q               <= '0;
            bus.ram_wr_en_out   <= 1'b0;
            bus.ram_wr_addr_out <= '0;
            bus.ram_wr_data_out <= '0;
            frame_rdy_out       <= 1'b0;
            for (int i = 0; i < CFG_BYTES; i++) begin
                cfg_q[i] <= cfg_default_byte(i);
            end
        end else begin
            bus.ram_wr_en_out <= wr_now;
            frame_rdy_out     <= frame_done;

            if ((state_q == IDLE) && bus.byte_rdy_in) begin
                addr_q      <= '0;
                addr_full_q <= 1'b0;
                wrote_q     <= 1'b0;
                idx_q       <= '0;
            end

            // Counter parks on the last address; the full flag drops everything after it
            if (wr_now) begin
                bus.ram_wr_addr_out <= addr_q;
                bus.ram_wr_data_out <= bus.byte_data_in;
                wrote_q             <= 1'b1;
                if (addr_q == ADDR_LAST) begin
                    addr_full_q <= 1'b1;
                end else begin
                    addr_q <= addr_q + 1'b1;
                end
            end

            if (cfg_now) begin
                cfg_q[idx_q] <= bus.byte_data_in;
                idx_q        <= idx_q + 1'b1;
            end
        end
    end

    assign cfg_data_out = cfg_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Drives two decoders (9-bit and 2-bit RAM address) with identical SPI frames.
module tb_spi_cmd_decoder;
    import led_ctrl_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        spi_cs_n_in;
    logic        byte_rdy;
    logic [7:0]  byte_dat;
    logic [31:0] cfg_a, cfg_b;
    logic        frm_a, frm_b;

    always #5 clk_in = ~clk_in;

    spi_cmd_decoder_if #(.ADDR_WIDTH(9)) bus_a ();
    spi_cmd_decoder_if #(.ADDR_WIDTH(2)) bus_b ();

    assign bus_a.byte_rdy_in  = byte_rdy;
    assign bus_a.byte_data_in = byte_dat;
    assign bus_b.byte_rdy_in  = byte_rdy;
    assign bus_b.byte_data_in = byte_dat;

    spi_cmd_decoder #(.ADDR_WIDTH(9), .CFG_BYTES(4)) dut_a (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .spi_cs_n_in   (spi_cs_n_in),
        .bus           (bus_a),
        .cfg_data_out  (cfg_a),
        .frame_rdy_out (frm_a)
    );

    spi_cmd_decoder #(.ADDR_WIDTH(2), .CFG_BYTES(4)) dut_b (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .spi_cs_n_in   (spi_cs_n_in),
        .bus           (bus_b),
        .cfg_data_out  (cfg_b),
        .frame_rdy_out (frm_b)
    );

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int         n;
        logic [7:0] b [8];
        bit         coin;
        int         exp_wr_a;
        int         exp_wr_b;
        int         exp_frm;
        logic [31:0] exp_cfg;
        bit         tbl;
    } vec_t;

    wr_t  obs_a[$], obs_b[$];
    int   frq_a[$], frq_b[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    logic prev_wr_a = 1'b0, prev_wr_b = 1'b0;
    logic [7:0] mcfg [4];
    vec_t tv [9];

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (bus_a.ram_wr_en_out) begin
            checks++;
            if (prev_wr_a) begin
                errors++;
                $display("FAIL wr_back_to_back_a: strobe high two cycles in a row at cycle %0d", cyc);
            end
            obs_a.push_back('{cyc, int'(bus_a.ram_wr_addr_out), int'(bus_a.ram_wr_data_out)});
        end
        if (bus_b.ram_wr_en_out) begin
            checks++;
            if (prev_wr_b) begin
                errors++;
                $display("FAIL wr_back_to_back_b: strobe high two cycles in a row at cycle %0d", cyc);
            end
            obs_b.push_back('{cyc, int'(bus_b.ram_wr_addr_out), int'(bus_b.ram_wr_data_out)});
        end
        prev_wr_a = bus_a.ram_wr_en_out;
        prev_wr_b = bus_b.ram_wr_en_out;
        if (frm_a) frq_a.push_back(cyc);
        if (frm_b) frq_b.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_cfg();
        return {mcfg[3], mcfg[2], mcfg[1], mcfg[0]};
    endfunction

    task automatic model_cfg_reset();
        logic [31:0] d;
        d = CFG_DEFAULT;
        for (int i = 0; i < 4; i++) mcfg[i] = d[8*i +: 8];
    endtask

    task automatic strobe(input logic [7:0] b, output int sc);
        byte_rdy = 1'b1;
        byte_dat = b;
        sc       = cyc;
        tick();
        byte_rdy = 1'b0;
        byte_dat = 8'h00;
    endtask

    task automatic check_dut(input string nm, input int depth, input vec_t v, input int scyc[8],
                             input int rise, input wr_t obs[$], input int frq[$],
                             input logic [31:0] cfg, input logic [31:0] exp_cfg,
                             input int tbl_wr, input int tbl_frm);
        wr_t exp[$];
        int  n_exp, f_exp;
        bit  is_data;
        is_data = (v.n > 0) && (v.b[0] == CMD_DATA_WR);
        if (is_data) begin
            for (int i = 1; i < v.n; i++) begin
                if (i - 1 < depth) exp.push_back('{scyc[i] + 1, i - 1, int'(v.b[i])});
            end
        end
        n_exp = (tbl_wr >= 0) ? tbl_wr : exp.size();
        f_exp = (tbl_frm >= 0) ? tbl_frm : ((is_data && v.n > 1) ? 1 : 0);

        checks++;
        if (obs.size() != n_exp) begin
            errors++;
            $display("FAIL wr_count_%s: got %0d writes expected %0d", nm, obs.size(), n_exp);
        end else if (n_exp > 0) begin
            checks++;
            for (int i = 0; i < obs.size(); i++) begin
                if (i >= exp.size() || obs[i] != exp[i]) begin
                    errors++;
                    if (i < exp.size())
                        $display("FAIL wr_data_%s: write %0d got cyc=%0d addr=%0d data=%h expected cyc=%0d addr=%0d data=%h",
                                 nm, i, obs[i].cyc, obs[i].addr, obs[i].data, exp[i].cyc, exp[i].addr, exp[i].data);
                    else
                        $display("FAIL wr_data_%s: write %0d got addr=%0d but none expected", nm, i, obs[i].addr);
                    break;
                end
            end
        end

        checks++;
        if (frq.size() != f_exp) begin
            errors++;
            $display("FAIL frame_count_%s: got %0d pulses expected %0d", nm, frq.size(), f_exp);
        end else if (f_exp == 1) begin
            chk({"frame_time_", nm}, 64'(frq[0]), 64'(rise + 4));
        end

        chk({"cfg_", nm}, 64'(cfg), 64'(exp_cfg));
    endtask

    task automatic do_frame(input vec_t v);
        int scyc[8];
        int rise, last;
        logic [31:0] exp_cfg;
        for (int i = 0; i < 8; i++) scyc[i] = 0;
        obs_a.delete(); obs_b.delete(); frq_a.delete(); frq_b.delete();
        spi_cs_n_in = 1'b0;
        repeat (3) tick();
        last = (v.coin && v.n > 0) ? v.n - 1 : v.n;
        for (int i = 0; i < last; i++) begin
            strobe(v.b[i], scyc[i]);
            repeat ($urandom_range(1, 4)) tick();
        end
        spi_cs_n_in = 1'b1;
        rise = cyc;
        if (last != v.n) begin
            repeat (3) tick();
            strobe(v.b[v.n-1], scyc[v.n-1]);
        end
        repeat (8) tick();

        if (v.n > 0 && v.b[0] == CMD_CONF_WR) begin
            for (int i = 1; i < v.n && i <= 4; i++) mcfg[i-1] = v.b[i];
        end
        exp_cfg = v.tbl ? v.exp_cfg : model_cfg();
        check_dut("a", 512, v, scyc, rise, obs_a, frq_a, cfg_a, exp_cfg,
                  v.tbl ? v.exp_wr_a : -1, v.tbl ? v.exp_frm : -1);
        check_dut("b", 4, v, scyc, rise, obs_b, frq_b, cfg_b, exp_cfg,
                  v.tbl ? v.exp_wr_b : -1, v.tbl ? v.exp_frm : -1);
    endtask

    initial begin
        vec_t v;
        int   sc, r;

        tv[0] = '{n:4, b:'{8'h2C,8'h11,8'h22,8'h33,8'h00,8'h00,8'h00,8'h00}, coin:0,
                  exp_wr_a:3, exp_wr_b:3, exp_frm:1, exp_cfg:32'h1628_2A14, tbl:1};
        tv[1] = '{n:6, b:'{8'h2A,8'h05,8'h0A,8'h0A,8'h05,8'hFF,8'h00,8'h00}, coin:0,
                  exp_wr_a:0, exp_wr_b:0, exp_frm:0, exp_cfg:32'h050A_0A05, tbl:1};
        tv[2] = '{n:7, b:'{8'h2C,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h00}, coin:0,
                  exp_wr_a:6, exp_wr_b:4, exp_frm:1, exp_cfg:32'h050A_0A05, tbl:1};
        tv[3] = '{n:4, b:'{8'h55,8'h01,8'h02,8'h03,8'h00,8'h00,8'h00,8'h00}, coin:0,
                  exp_wr_a:0, exp_wr_b:0, exp_frm:0, exp_cfg:32'h050A_0A05, tbl:1};
        tv[4] = '{n:2, b:'{8'h2C,8'hAA,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, coin:0,
                  exp_wr_a:1, exp_wr_b:1, exp_frm:1, exp_cfg:32'h050A_0A05, tbl:1};
        tv[5] = '{n:3, b:'{8'h2C,8'h5A,8'h6B,8'h00,8'h00,8'h00,8'h00,8'h00}, coin:1,
                  exp_wr_a:2, exp_wr_b:2, exp_frm:1, exp_cfg:32'h050A_0A05, tbl:1};
        tv[6] = '{n:1, b:'{8'h2C,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, coin:1,
                  exp_wr_a:0, exp_wr_b:0, exp_frm:0, exp_cfg:32'h050A_0A05, tbl:1};
        tv[7] = '{n:1, b:'{8'h2C,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, coin:0,
                  exp_wr_a:0, exp_wr_b:0, exp_frm:0, exp_cfg:32'h050A_0A05, tbl:1};
        tv[8] = '{n:2, b:'{8'h2A,8'h77,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, coin:0,
                  exp_wr_a:0, exp_wr_b:0, exp_frm:0, exp_cfg:32'h050A_0A77, tbl:1};

        rst_in      = 1'b1;
        spi_cs_n_in = 1'b1;
        byte_rdy    = 1'b0;
        byte_dat    = 8'h00;
        model_cfg_reset();
        repeat (2) tick();
        chk("reset_outs_a", {bus_a.ram_wr_en_out, bus_a.ram_wr_addr_out, bus_a.ram_wr_data_out, frm_a}, 64'h0);
        chk("reset_outs_b", {bus_b.ram_wr_en_out, bus_b.ram_wr_addr_out, bus_b.ram_wr_data_out, frm_b}, 64'h0);
        chk("reset_cfg_a", 64'(cfg_a), 64'h1628_2A14);
        rst_in = 1'b0;
        repeat (4) tick();

        for (int i = 0; i < 9; i++) do_frame(tv[i]);

        // Reset in the middle of a data frame
        spi_cs_n_in = 1'b0;
        repeat (3) tick();
        strobe(8'h2C, sc); repeat (2) tick();
        strobe(8'h11, sc); repeat (2) tick();
        strobe(8'h22, sc); repeat (2) tick();
        rst_in = 1'b1;
        tick();
        chk("midrst_outs_a", {bus_a.ram_wr_en_out, bus_a.ram_wr_addr_out, bus_a.ram_wr_data_out, frm_a}, 64'h0);
        chk("midrst_outs_b", {bus_b.ram_wr_en_out, bus_b.ram_wr_addr_out, bus_b.ram_wr_data_out, frm_b}, 64'h0);
        chk("midrst_cfg_a", 64'(cfg_a), 64'h1628_2A14);
        chk("midrst_cfg_b", 64'(cfg_b), 64'h1628_2A14);
        rst_in = 1'b0;
        model_cfg_reset();
        frq_a.delete(); frq_b.delete();
        repeat (2) tick();
        spi_cs_n_in = 1'b1;
        repeat (10) tick();
        chk("midrst_no_frame_a", 64'(frq_a.size()), 64'h0);
        chk("midrst_no_frame_b", 64'(frq_b.size()), 64'h0);
        v = '{n:3, b:'{8'h2C,8'hAB,8'hCD,8'h00,8'h00,8'h00,8'h00,8'h00}, coin:0,
              exp_wr_a:0, exp_wr_b:0, exp_frm:0, exp_cfg:32'h0, tbl:0};
        do_frame(v);

        for (int k = 0; k < 40; k++) begin
            v.n = $urandom_range(0, 7);
            for (int i = 0; i < 8; i++) v.b[i] = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 3);
            if (r == 0)      v.b[0] = CMD_CONF_WR;
            else if (r < 3)  v.b[0] = CMD_DATA_WR;
            v.coin     = (v.n > 0) && ($urandom_range(0, 3) == 0);
            v.exp_wr_a = 0;
            v.exp_wr_b = 0;
            v.exp_frm  = 0;
            v.exp_cfg  = 32'h0;
            v.tbl      = 1'b0;
            do_frame(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
